// File: rtl/cache_arbiter_pkg.sv
// Shared types and line/beat geometry for the icache/dcache memory arbiter.
package mem_types;

  localparam int unsigned LINE_W  = 256;
  localparam int unsigned BURST_W = 64;
  localparam int unsigned BEATS   = LINE_W / BURST_W;

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR,
    DONE
  } arb_state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_t;

endpackage

// File: rtl/cache_arbiter_burst_buffer.sv
// Line buffer for cache_arbiter: parallel line load, beat-indexed fill and
// read-out, and the beat counter with its last-beat flag.
module burst_buffer
  import mem_types::*;
#(
  parameter int unsigned LINE_W  = mem_types::LINE_W,
  parameter int unsigned BURST_W = mem_types::BURST_W
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [LINE_W-1:0]  line_i,
  input  logic               clr_i,
  input  logic               wr_beat_i,
  input  logic               step_i,
  input  logic [BURST_W-1:0] beat_i,
  output logic [BURST_W-1:0] beat_o,
  output logic [LINE_W-1:0]  line_o,
  output logic               last_o
);

  localparam int unsigned NBEATS = LINE_W / BURST_W;
  localparam int unsigned CNT_W  = $clog2(NBEATS);

  logic [BURST_W-1:0] beat_q [NBEATS];
  logic [CNT_W-1:0]   cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned b = 0; b < NBEATS; b++) beat_q[b] <= '0;
      cnt_q <= '0;
    end else begin
      if (load_i) begin
        for (int unsigned b = 0; b < NBEATS; b++) beat_q[b] <= line_i[b*BURST_W +: BURST_W];
      end else if (wr_beat_i) begin
        beat_q[cnt_q] <= beat_i;
      end
      // Counter wraps naturally after the last beat; only meaningful inside a burst.
      if (clr_i) cnt_q <= '0;
      else if (step_i) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    line_o = '0;
    for (int unsigned b = 0; b < NBEATS; b++) line_o[b*BURST_W +: BURST_W] = beat_q[b];
  end

  assign beat_o = beat_q[cnt_q];
  assign last_o = (cnt_q == CNT_W'(NBEATS - 1));

endmodule

// File: rtl/cache_arbiter.sv
// Arbitrates icache/dcache line requests onto one 4-beat burst memory port.
// Optional CACHE_ARB_ROUND_ROBIN_EN: toggling priority pointer instead of dcache-first.
module cache_arbiter
  import mem_types::*;
#(
  parameter int unsigned LINE_W  = mem_types::LINE_W,
  parameter int unsigned BURST_W = mem_types::BURST_W,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic               i_read,
  output logic [LINE_W-1:0]  i_rdata,
  output logic               i_resp,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [LINE_W-1:0]  d_wdata,
  output logic [LINE_W-1:0]  d_rdata,
  output logic               d_resp,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_read,
  output logic               mem_write,
  output logic [BURST_W-1:0] mem_wdata,
  input  logic [BURST_W-1:0] mem_rdata,
  input  logic               mem_resp
);

  localparam int unsigned       OFF_W    = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  arb_state_t         state_q, state_d;
  arb_owner_t         owner_q, owner_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               d_req, grant_d;
  logic               buf_load, buf_clr, buf_wr, buf_step, buf_last;
  logic [BURST_W-1:0] buf_beat;
  logic [LINE_W-1:0]  buf_line;

  assign d_req = d_read | d_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  arb_owner_t prio_q, prio_d;
  assign grant_d = d_req && (!i_read || prio_q == OWN_D);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      addr_q  <= '0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      prio_q  <= OWN_D;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
      prio_q  <= prio_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    addr_d   = addr_q;
    buf_load = 1'b0;
    buf_clr  = 1'b0;
    buf_wr   = 1'b0;
    buf_step = 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    prio_d   = prio_q;
`endif
    case (state_q)
      IDLE: begin
        if (d_req || i_read) begin
          buf_clr = 1'b1;
          if (grant_d) begin
            owner_d = OWN_D;
            addr_d  = d_addr & ~OFF_MASK;
            // A simultaneous read+write from the dcache is served as the writeback.
            if (d_write) begin
              buf_load = 1'b1;
              state_d  = D_WR;
            end else begin
              state_d  = D_RD;
            end
          end else begin
            owner_d = OWN_I;
            addr_d  = i_addr & ~OFF_MASK;
            state_d = I_RD;
          end
        end
      end
      I_RD, D_RD: begin
        if (mem_resp) begin
          buf_wr   = 1'b1;
          buf_step = 1'b1;
          if (buf_last) state_d = DONE;
        end
      end
      D_WR: begin
        if (mem_resp) begin
          buf_step = 1'b1;
          if (buf_last) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        prio_d  = (prio_q == OWN_D) ? OWN_I : OWN_D;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  burst_buffer #(
    .LINE_W  (LINE_W),
    .BURST_W (BURST_W)
  ) u_buf (
    .clk_i     (clk),
    .rst_ni    (rst),
    .load_i    (buf_load),
    .line_i    (d_wdata),
    .clr_i     (buf_clr),
    .wr_beat_i (buf_wr),
    .step_i    (buf_step),
    .beat_i    (mem_rdata),
    .beat_o    (buf_beat),
    .line_o    (buf_line),
    .last_o    (buf_last)
  );

  assign mem_addr  = addr_q;
  assign mem_read  = (state_q == I_RD) || (state_q == D_RD);
  assign mem_write = (state_q == D_WR);
  assign mem_wdata = mem_write ? buf_beat : '0;
  assign i_resp    = (state_q == DONE) && (owner_q == OWN_I);
  assign d_resp    = (state_q == DONE) && (owner_q == OWN_D);
  assign i_rdata   = buf_line;
  assign d_rdata   = buf_line;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed vectors, reset abort, random traffic.
module tb_cache_arbiter;

  logic         clk, rst;
  logic [31:0]  i_addr, d_addr, mem_addr;
  logic         i_read, i_resp, d_read, d_write, d_resp;
  logic [255:0] i_rdata, d_rdata, d_wdata;
  logic         mem_read, mem_write, mem_resp;
  logic [63:0]  mem_wdata, mem_rdata;

  int   total = 0;
  int   bad   = 0;
  logic ptr_m;   // reference priority pointer: 1 = dcache

  cache_arbiter #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd_line();
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = $urandom;
    return l;
  endfunction

  // Acts as memory for one burst whose grant happens at the next posedge.
  // gaps[2k+:2] = idle cycles inserted before beat k.
  task automatic serve(input logic own_d, input logic is_wr, input logic [31:0] exp_addr,
                       input logic [255:0] wline, input logic [255:0] rline,
                       input logic [7:0] gaps, input string tag);
    logic [63:0] seen[$];
    logic [63:0] want[$];
    int ctl_err = 0;
    int seq_err = 0;
    for (int k = 0; k < 4; k++)
      repeat (int'(gaps[2*k +: 2]) + 1) want.push_back(wline[64*k +: 64]);
    @(posedge clk);
    @(negedge clk);
    chk({tag, " mem_read"},  256'(mem_read),  256'(!is_wr));
    chk({tag, " mem_write"}, 256'(mem_write), 256'(is_wr));
    chk({tag, " mem_addr"},  256'(mem_addr),  256'(exp_addr));
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g <= int'(gaps[2*k +: 2]); g++) begin
        if (mem_read !== !is_wr || mem_write !== is_wr || mem_addr !== exp_addr ||
            i_resp !== 1'b0 || d_resp !== 1'b0) ctl_err++;
        if (is_wr) seen.push_back(mem_wdata);
        mem_resp  = (g == int'(gaps[2*k +: 2]));
        mem_rdata = mem_resp ? rline[64*k +: 64] : {$urandom, $urandom};
        @(negedge clk);
      end
    end
    mem_resp = 1'b0;
    chk({tag, " burst ctl stable"}, 256'(ctl_err), 256'(0));
    if (is_wr) begin
      if (seen.size() != want.size()) seq_err = 100 + seen.size();
      else for (int i = 0; i < want.size(); i++) if (seen[i] !== want[i]) seq_err++;
      chk({tag, " wdata seq"}, 256'(seq_err), 256'(0));
    end
    chk({tag, " owner resp"}, 256'(own_d ? d_resp : i_resp), 256'(1));
    chk({tag, " other resp"}, 256'(own_d ? i_resp : d_resp), 256'(0));
    chk({tag, " done idle port"}, 256'({mem_read, mem_write}), 256'(0));
    if (!is_wr) chk({tag, " rdata"}, own_d ? d_rdata : i_rdata, rline);
    if (own_d) begin d_read = 1'b0; d_write = 1'b0; end
    else i_read = 1'b0;
    ptr_m = !ptr_m;
    @(negedge clk);
    chk({tag, " resp single"}, 256'({i_resp, d_resp}), 256'(0));
  endtask

  // Reference-model transaction: grant order from the priority rule, then each burst.
  task automatic txn(input logic ir, input logic dr, input logic dw,
                     input logic [31:0] ia, input logic [31:0] da,
                     input logic [255:0] wd, input string tag);
    logic dreq, first_d;
    dreq    = dr | dw;
    i_read  = ir; d_read = dr; d_write = dw;
    i_addr  = ia; d_addr = da; d_wdata = wd;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    first_d = dreq && (!ir || ptr_m);
`else
    first_d = dreq;
`endif
    serve(first_d, first_d & dw, (first_d ? da : ia) & 32'hFFFF_FFE0, wd, rnd_line(),
          8'($urandom), tag);
    if (ir && dreq)
      serve(!first_d, !first_d & dw, (!first_d ? da : ia) & 32'hFFFF_FFE0, wd, rnd_line(),
            8'($urandom), {tag, " 2nd"});
  endtask

  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] ia, da;
    logic        exp_d, exp_wr;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t         vt [6];
  logic [255:0] line_a, line_w;

  initial begin
    rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    ptr_m = 1'b1;

    vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0064, 32'h0,         1'b0, 1'b0, 32'h0000_0060};
    vt[1] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h1234_5678, 1'b1, 1'b0, 32'h1234_5660};
    vt[2] = '{1'b0, 1'b0, 1'b1, 32'h0,         32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFE0};
    vt[3] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h0000_0ABC, 1'b1, 1'b1, 32'h0000_0AA0};
    vt[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0000_2020, 1'b1, 1'b0, 32'h0000_2020};
    vt[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_301F, 32'h0000_4040, 1'b1, 1'b1, 32'h0000_4040};

    @(negedge clk);
    chk("reset ctl", 256'({mem_read, mem_write, i_resp, d_resp}), 256'(0));
    chk("reset mem_addr", 256'(mem_addr), 256'(0));
    chk("reset mem_wdata", 256'(mem_wdata), 256'(0));
    chk("reset i_rdata", i_rdata, 256'(0));
    chk("reset d_rdata", d_rdata, 256'(0));
    rst = 1'b1;
    @(negedge clk);

    // icache read with known beats
    line_a = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
    i_read = 1'b1; i_addr = 32'h0000_0064;
    serve(1'b0, 1'b0, 32'h0000_0060, '0, line_a, 8'h00, "icache read");

    // dcache writeback with a stall before the third beat
    line_w = {{8{8'hA3}}, {8{8'hA2}}, {8{8'hA1}}, {8{8'hA0}}};
    d_write = 1'b1; d_addr = 32'h0000_0180; d_wdata = line_w;
    serve(1'b1, 1'b1, 32'h0000_0180, line_w, rnd_line(), 8'b00_01_00_00, "dcache wb gap");

    for (int v = 0; v < 6; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      i_read = vt[v].ir; d_read = vt[v].dr; d_write = vt[v].dw;
      i_addr = vt[v].ia; d_addr = vt[v].da; d_wdata = rnd_line();
      serve(vt[v].exp_d, vt[v].exp_wr, vt[v].exp_addr, d_wdata, rnd_line(), 8'($urandom), tag);
      if (vt[v].ir && (vt[v].dr || vt[v].dw))
        serve(!vt[v].exp_d, !vt[v].exp_d & vt[v].dw,
              (vt[v].exp_d ? vt[v].ia : vt[v].da) & 32'hFFFF_FFE0,
              d_wdata, rnd_line(), 8'($urandom), {tag, " 2nd"});
    end

    // reset after two beats of an icache read aborts the burst
    i_read = 1'b1; i_addr = 32'h0000_0200;
    @(posedge clk);
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = 64'h0101_0101_0101_0101;
    @(negedge clk);
    mem_rdata = 64'h0202_0202_0202_0202;
    @(negedge clk);
    mem_resp = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("abort mem_read", 256'(mem_read), 256'(0));
    chk("abort i_resp", 256'(i_resp), 256'(0));
    chk("abort buffer", i_rdata, 256'(0));
    chk("abort mem_addr", 256'(mem_addr), 256'(0));
    i_read = 1'b0; ptr_m = 1'b1;
    @(negedge clk);
    chk("abort no resp", 256'({i_resp, d_resp}), 256'(0));
    rst = 1'b1;
    @(negedge clk);
    txn(1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0, '0, "reissue");

    // back-to-back simultaneous requests
    for (int r = 0; r < 3; r++)
      txn(1'b1, 1'b1, 1'b0, 32'h0000_5000 + 32'(r * 64), 32'h0000_6000 + 32'(r * 64), '0,
          $sformatf("both%0d", r));

    for (int n = 0; n < 40; n++) begin
      logic [2:0] sel;
      sel = 3'($urandom_range(1, 7));
      txn(sel[0], sel[1], sel[2], $urandom, $urandom, rnd_line(), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Shares the single burst memory port between the instruction cache and the data cache of the mp4 pipelined RV32I core. Each cache issues whole-line (256-bit) read or write requests. The arbiter grants one requester at a time and serializes or deserializes the line as a 4-beat, 64-bit burst on the memory port. It returns a one-cycle response to the granted cache. It sits between the two cache miss interfaces and the top-level `mem_*` port.

## Interface
Parameters:
- `LINE_W`, 256, cache line width in bits
- `BURST_W`, 64, memory beat width; `BEATS = LINE_W/BURST_W` (4)
- `ADDR_W`, 32, address width

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_addr`  in  ADDR_W  icache line address
- `i_read`  in  1  icache line read request, held until `i_resp`
- `i_rdata`  out  LINE_W  line returned to icache
- `i_resp`  out  1  one-cycle completion to icache
- `d_addr`  in  ADDR_W  dcache line address
- `d_read`  in  1  dcache line read request
- `d_write`  in  1  dcache line writeback request
- `d_wdata`  in  LINE_W  writeback line
- `d_rdata`  out  LINE_W  line returned to dcache
- `d_resp`  out  1  one-cycle completion to dcache
- `mem_addr`  out  ADDR_W  burst address, low 5 bits zero
- `mem_read`  out  1  burst read, held until the last beat
- `mem_write`  out  1  burst write, held until the last beat
- `mem_wdata`  out  BURST_W  current write beat
- `mem_rdata`  in  BURST_W  current read beat
- `mem_resp`  in  1  beat accepted or valid, one per beat

## Operation
- States: IDLE, I_RD, D_RD, D_WR, DONE.
- IDLE:
  - Sample requests.
  - Grant follows the priority rule (see Configuration).
  - `d_write` with `d_read` both high: treat as write.
  - On grant, latch the requester's address with the low 5 bits forced to 0. Latch `d_wdata` into the line buffer for writes. Clear the beat counter.
- I_RD / D_RD:
  - `mem_read`=1.
  - On each `mem_resp`, store `mem_rdata` into buffer slice [count*64 +: 64]. Beat 0 fills bits 63:0.
  - Increment count. On the beat with count==BEATS-1, go to DONE.
- D_WR:
  - `mem_write`=1, `mem_wdata` = buffer slice [count].
  - Advance on `mem_resp`. After the last beat, go to DONE.
- DONE:
  - Pulse `i_resp` or `d_resp` for the granted owner.
  - `i_rdata`/`d_rdata` = buffer, valid this cycle and held until the next grant.
  - Go to IDLE.
- Beat counter is 2 bits and wraps 3→0; it is only meaningful inside a burst.
- A request still high in the DONE cycle is ignored. Requesters drop their request on the cycle after their response.
- Reset mid-burst aborts the burst:
  - State returns to IDLE and the buffer and count are cleared.
  - Memory sees `mem_read`/`mem_write` drop asynchronously.
  - No response is issued.

## Timing
- Reset values: every output is 0, state is IDLE, and the priority pointer selects dcache.
- A request seen in IDLE at edge t drives `mem_read`/`mem_write` and `mem_addr` from cycle t+1. These are decoded from registered state, not from requester inputs.
- With `mem_resp` high on 4 consecutive cycles t+1..t+4, DONE is at t+5 and the response pulses at t+5. The next grant can occur at the t+6 edge.
- `mem_addr`, `mem_read` and `mem_write` are stable for the whole burst. `mem_wdata` changes only on the edge after a `mem_resp`.
- Gaps in `mem_resp` stall the burst indefinitely; there is no timeout.

## Configuration
- `CACHE_ARB_ROUND_ROBIN_EN` defined:
  - A one-bit priority pointer flips to the other requester after every completed grant.
  - When both caches request, the pointer's target wins.
- Undefined: fixed priority, dcache always wins over icache.

## Structure
- Shared package `mem_types`:
  - `arb_state_t` enum.
  - `LINE_W`, `BURST_W`, `BEATS` constants.
  - `arb_owner_t` enum {OWN_I, OWN_D}.
- One sub-module `burst_buffer`:
  - LINE_W register with beat-indexed write port and read mux.
  - Parallel line load.
  - Owns the beat counter and a last-beat flag.

## Test plan
- icache read only, addr 0x0000_0064, memory returns beats 0x11..,0x22..,0x33..,0x44.. with no gaps -> `mem_addr`=0x60. `i_resp` pulses at t+5 with `i_rdata`={0x44..,0x33..,0x22..,0x11..}. `d_resp` stays 0.
- dcache writeback, `d_wdata`=256'h(A3,A2,A1,A0), one idle cycle between beats 2 and 3 -> `mem_wdata` sequence A0,A1,A2,A2,A3. `mem_write` is held for 5 cycles, then `d_resp` pulses once.
- Both caches request in the same cycle, fixed priority -> dcache burst first, then icache burst. Each response pulses exactly once.
- Same as the previous test with `CACHE_ARB_ROUND_ROBIN_EN`, issued three times back-to-back -> grant order D, I, D, I, ...
- Assert `rst` low after beat 2 of an icache read -> `mem_read` falls immediately with no `i_resp`. After release, a reissued request completes normally with fresh data.
- `d_read` and `d_write` both high -> a write burst is performed and `mem_read` never asserts.
